// File: rtl/systolic_pe_if.sv
// Bus bundle for one systolic PE: west/north operands in, east/south forwards out,
// plus control and the OS result port.
interface systolic_pe_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20
);
  logic                  EN;
  logic                  MODE;
  logic                  SIGNED_MODE;
  logic                  LoadWeight;
  logic                  LastIn;
  logic [DATA_WIDTH-1:0] InputIn;
  logic [DATA_WIDTH-1:0] WeightIn;
  logic [ACC_WIDTH-1:0]  PsumIn;
  logic [DATA_WIDTH-1:0] InputOut;
  logic [DATA_WIDTH-1:0] WeightOut;
  logic                  LastOut;
  logic [ACC_WIDTH-1:0]  PsumOut;
  logic [ACC_WIDTH-1:0]  Result;
  logic                  ResultValid;
  logic                  ResultOvf;

  modport master (
    output EN, MODE, SIGNED_MODE, LoadWeight, LastIn, InputIn, WeightIn, PsumIn,
    input  InputOut, WeightOut, LastOut, PsumOut, Result, ResultValid, ResultOvf
  );

  modport slave (
    input  EN, MODE, SIGNED_MODE, LoadWeight, LastIn, InputIn, WeightIn, PsumIn,
    output InputOut, WeightOut, LastOut, PsumOut, Result, ResultValid, ResultOvf
  );
endinterface

// File: rtl/systolic_pe.sv
// Multiply-accumulate PE: output-stationary accumulation with LastIn capture, or
// weight-stationary partial-sum chaining; saturating arithmetic, signed or unsigned.
module systolic_pe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 20
) (
  input  logic          CLK,
  input  logic          ASYNC_RST,
  input  logic          SYNC_RST,
  systolic_pe_if.slave  bus
);

  typedef enum logic {MODE_OS = 1'b0, MODE_WS = 1'b1} mode_e;

  localparam int unsigned PW = 2 * DATA_WIDTH;

  mode_e                 mode_q, mode_d, req_mode;
  logic [DATA_WIDTH-1:0] in_q, in_d, wo_q, wo_d, sw_q, sw_d;
  logic                  lo_q, lo_d, rv_q, rv_d, rovf_q, rovf_d, oacc_q, oacc_d;
  logic [ACC_WIDTH-1:0]  psum_q, psum_d, res_q, res_d, acc_q, acc_d;

  logic [DATA_WIDTH-1:0] op;
  logic [PW-1:0]         a_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0]  addend, mac_sum;
  logic                  mac_ovf;

  // Returns {ovf, clamped sum}; one guard bit detects overflow in either signedness.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [PW-1:0]        p,
                                                 input logic                 sgn);
    logic [ACC_WIDTH:0] sum;
    sum = {sgn & a[ACC_WIDTH-1], a} + {{(ACC_WIDTH + 1 - PW){sgn & p[PW-1]}}, p};
    if (sgn) begin
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
        return sum[ACC_WIDTH] ? {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}}
                              : {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
      return {1'b0, sum[ACC_WIDTH-1:0]};
    end
    if (sum[ACC_WIDTH])
      return {1'b1, {ACC_WIDTH{1'b1}}};
    return {1'b0, sum[ACC_WIDTH-1:0]};
  endfunction

  always_comb begin
    req_mode = mode_e'(bus.MODE);
    op       = (req_mode == MODE_WS) ? sw_q : bus.WeightIn;
    a_ext    = {{DATA_WIDTH{bus.SIGNED_MODE & bus.InputIn[DATA_WIDTH-1]}}, bus.InputIn};
    b_ext    = {{DATA_WIDTH{bus.SIGNED_MODE & op[DATA_WIDTH-1]}}, op};
    // Truncated product of sign-extended operands equals the two's-complement product.
    prod     = a_ext * b_ext;
    addend   = (req_mode == MODE_WS) ? bus.PsumIn : acc_q;
    {mac_ovf, mac_sum} = sat_add(addend, prod, bus.SIGNED_MODE);
  end

  always_comb begin
    mode_d = mode_q;
    in_d   = in_q;
    wo_d   = wo_q;
    lo_d   = lo_q;
    sw_d   = sw_q;
    psum_d = psum_q;
    res_d  = res_q;
    rv_d   = 1'b0;
    rovf_d = rovf_q;
    acc_d  = acc_q;
    oacc_d = oacc_q;

    if (SYNC_RST) begin
      mode_d = MODE_OS;
      in_d   = '0;
      wo_d   = '0;
      lo_d   = 1'b0;
      psum_d = '0;
      res_d  = '0;
      rovf_d = 1'b0;
      acc_d  = '0;
      oacc_d = 1'b0;
    end else if (bus.EN) begin
      in_d   = bus.InputIn;
      wo_d   = bus.WeightIn;
      lo_d   = bus.LastIn;
      mode_d = req_mode;
      if (req_mode == MODE_OS)
        psum_d = '0;
      if (req_mode != mode_q) begin
        acc_d  = '0;
        oacc_d = 1'b0;
      end else if (req_mode == MODE_OS) begin
        if (bus.LastIn) begin
          res_d  = mac_sum;
          rovf_d = oacc_q | mac_ovf;
          rv_d   = 1'b1;
          acc_d  = '0;
          oacc_d = 1'b0;
        end else begin
          acc_d  = mac_sum;
          oacc_d = oacc_q | mac_ovf;
        end
      end else if (bus.LoadWeight) begin
        sw_d   = bus.WeightIn;
        psum_d = bus.PsumIn;
      end else begin
        psum_d = mac_sum;
      end
    end
  end

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      mode_q <= MODE_OS;
      in_q   <= '0;
      wo_q   <= '0;
      lo_q   <= 1'b0;
      sw_q   <= '0;
      psum_q <= '0;
      res_q  <= '0;
      rv_q   <= 1'b0;
      rovf_q <= 1'b0;
      acc_q  <= '0;
      oacc_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      in_q   <= in_d;
      wo_q   <= wo_d;
      lo_q   <= lo_d;
      sw_q   <= sw_d;
      psum_q <= psum_d;
      res_q  <= res_d;
      rv_q   <= rv_d;
      rovf_q <= rovf_d;
      acc_q  <= acc_d;
      oacc_q <= oacc_d;
    end
  end

  assign bus.InputOut    = in_q;
  assign bus.WeightOut   = wo_q;
  assign bus.LastOut     = lo_q;
  assign bus.PsumOut     = psum_q;
  assign bus.Result      = res_q;
  assign bus.ResultValid = rv_q;
  assign bus.ResultOvf   = rovf_q;

endmodule

// File: tb/tb_systolic_pe.sv
// Directed bench for systolic_pe: vector table for OS/WS/mode-change behaviour,
// hand sequences for EN hold, resets and 16-bit saturation.
module tb_systolic_pe;

  logic CLK = 1'b0;
  logic ASYNC_RST;
  logic SYNC_RST;

  always #5 CLK = ~CLK;

  systolic_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(20)) bus_a ();
  systolic_pe_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) bus_b ();

  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(20)) dut_a (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .bus(bus_a.slave));
  systolic_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16)) dut_b (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .bus(bus_b.slave));

  typedef struct {
    logic        mode, sgn, lw, last;
    logic [7:0]  in, wt;
    logic [19:0] psum;
    logic [19:0] e_res;
    logic        e_rv, e_ovf;
    logic [19:0] e_psum;
    logic [7:0]  e_io, e_wo;
    logic        e_lo;
  } vec_t;

  vec_t vecs [18];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic mode, input logic sgn, input logic lw,
                         input logic last, input logic [7:0] in, input logic [7:0] wt,
                         input logic [19:0] psum);
    bus_a.EN = en; bus_a.MODE = mode; bus_a.SIGNED_MODE = sgn; bus_a.LoadWeight = lw;
    bus_a.LastIn = last; bus_a.InputIn = in; bus_a.WeightIn = wt; bus_a.PsumIn = psum;
  endtask

  task automatic chk_a(input string tag, input logic [19:0] res, input logic rv,
                       input logic ovf, input logic [19:0] psum, input logic [7:0] io,
                       input logic [7:0] wo, input logic lo);
    chk({tag, " Result"},      32'(bus_a.Result),      32'(res));
    chk({tag, " ResultValid"}, 32'(bus_a.ResultValid), 32'(rv));
    chk({tag, " ResultOvf"},   32'(bus_a.ResultOvf),   32'(ovf));
    chk({tag, " PsumOut"},     32'(bus_a.PsumOut),     32'(psum));
    chk({tag, " InputOut"},    32'(bus_a.InputOut),    32'(io));
    chk({tag, " WeightOut"},   32'(bus_a.WeightOut),   32'(wo));
    chk({tag, " LastOut"},     32'(bus_a.LastOut),     32'(lo));
  endtask

  initial begin
    //            mode sgn lw last in     wt     psum       res       rv ovf psum       io     wo     lo
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,8'h05,8'h03,20'h0,     20'h0,    1'b0,1'b0,20'h0,    8'h05,8'h03,1'b0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,8'h07,8'h02,20'h0,     20'd29,   1'b1,1'b0,20'h0,    8'h07,8'h02,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,20'h0,     20'd29,   1'b0,1'b0,20'h0,    8'h00,8'h00,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,8'hFC,8'h03,20'h0,     20'd29,   1'b0,1'b0,20'h0,    8'hFC,8'h03,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,8'h02,8'h05,20'h0,     20'hFFFFE,1'b1,1'b0,20'h0,    8'h02,8'h05,1'b1};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b1,8'h03,8'hFF,20'h0,     20'hFFFFD,1'b1,1'b0,20'h0,    8'h03,8'hFF,1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,8'h01,8'h01,20'h0,     20'd1,    1'b1,1'b0,20'h0,    8'h01,8'h01,1'b1};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,8'h09,8'h09,20'd55,    20'd1,    1'b0,1'b0,20'h0,    8'h09,8'h09,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b1,1'b0,8'h00,8'h06,20'd100,   20'd1,    1'b0,1'b0,20'd100,  8'h00,8'h06,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,8'h04,8'h00,20'd100,   20'd1,    1'b0,1'b0,20'd124,  8'h04,8'h00,1'b0};
    vecs[10] = '{1'b1,1'b1,1'b0,1'b0,8'hFE,8'h00,20'd5,     20'd1,    1'b0,1'b0,20'hFFFF9,8'hFE,8'h00,1'b0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0,8'hFF,8'h00,20'hFFFFF, 20'd1,    1'b0,1'b0,20'hFFFFF,8'hFF,8'h00,1'b0};
    vecs[12] = '{1'b1,1'b1,1'b0,1'b0,8'h80,8'h00,20'h80005, 20'd1,    1'b0,1'b0,20'h80000,8'h80,8'h00,1'b0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b0,8'h05,8'h03,20'h0,     20'd1,    1'b0,1'b0,20'h0,    8'h05,8'h03,1'b0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0,8'h05,8'h03,20'h0,     20'd1,    1'b0,1'b0,20'h0,    8'h05,8'h03,1'b0};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0,8'h01,8'h01,20'h0,     20'd1,    1'b0,1'b0,20'h0,    8'h01,8'h01,1'b0};
    vecs[16] = '{1'b0,1'b0,1'b0,1'b0,8'h01,8'h01,20'h0,     20'd1,    1'b0,1'b0,20'h0,    8'h01,8'h01,1'b0};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b1,8'h02,8'h02,20'h0,     20'd4,    1'b1,1'b0,20'h0,    8'h02,8'h02,1'b1};

    ASYNC_RST = 1'b1;
    SYNC_RST  = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 20'h0);
    bus_b.EN = 1'b0; bus_b.MODE = 1'b0; bus_b.SIGNED_MODE = 1'b0; bus_b.LoadWeight = 1'b0;
    bus_b.LastIn = 1'b0; bus_b.InputIn = '0; bus_b.WeightIn = '0; bus_b.PsumIn = '0;
    #12;
    ASYNC_RST = 1'b0;
    chk_a("reset", 20'h0, 1'b0, 1'b0, 20'h0, 8'h0, 8'h0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      drive_a(1'b1, vecs[i].mode, vecs[i].sgn, vecs[i].lw, vecs[i].last,
              vecs[i].in, vecs[i].wt, vecs[i].psum);
      step();
      chk_a($sformatf("v%0d", i), vecs[i].e_res, vecs[i].e_rv, vecs[i].e_ovf,
            vecs[i].e_psum, vecs[i].e_io, vecs[i].e_wo, vecs[i].e_lo);
    end

    // ResultValid drops with EN low; LastIn under EN=0 is ignored.
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 8'h03, 20'h0);
    step();
    chk_a("en0_rv_clear", 20'd4, 1'b0, 1'b0, 20'h0, 8'h02, 8'h02, 1'b1);
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h03, 20'h0);
    step();
    drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 8'h09, 20'h0);
    step();
    chk_a("en0_last_ignored", 20'd4, 1'b0, 1'b0, 20'h0, 8'h05, 8'h03, 1'b0);
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 20'h0);
    step();
    chk_a("en0_continue", 20'd16, 1'b1, 1'b0, 20'h0, 8'h01, 8'h01, 1'b1);

    // WS: load, MAC, hold under EN=0, sync clear keeps the stationary weight.
    drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 20'h0);
    step();
    drive_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0, 8'h06, 20'h0);
    step();
    drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 20'd100);
    step();
    chk_a("ws_mac", 20'd16, 1'b0, 1'b0, 20'd124, 8'h04, 8'h00, 1'b0);
    drive_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd77, 8'd77, 20'd9);
    for (int c = 0; c < 3; c++) begin
      step();
      chk_a($sformatf("ws_hold%0d", c), 20'd16, 1'b0, 1'b0, 20'd124, 8'h04, 8'h00, 1'b0);
    end
    SYNC_RST = 1'b1;
    step();
    chk_a("sync_rst", 20'h0, 1'b0, 1'b0, 20'h0, 8'h0, 8'h0, 1'b0);
    SYNC_RST = 1'b0;
    drive_a(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 20'h0);
    step();
    chk_a("ws_resync", 20'h0, 1'b0, 1'b0, 20'h0, 8'h02, 8'h00, 1'b0);
    step();
    chk_a("ws_weight_kept", 20'h0, 1'b0, 1'b0, 20'd12, 8'h02, 8'h00, 1'b0);

    // Asynchronous reset between edges, mid-accumulation.
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 20'h0);
    step();
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 20'h0);
    step();
    chk_a("pre_arst_cap", 20'd1, 1'b1, 1'b0, 20'h0, 8'h01, 8'h01, 1'b1);
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h03, 20'h0);
    step();
    #2 ASYNC_RST = 1'b1;
    #1;
    chk_a("arst", 20'h0, 1'b0, 1'b0, 20'h0, 8'h0, 8'h0, 1'b0);
    ASYNC_RST = 1'b0;
    drive_a(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 20'h0);
    step();
    chk_a("post_arst", 20'd1, 1'b1, 1'b0, 20'h0, 8'h01, 8'h01, 1'b1);

    // 16-bit unsigned saturation, then a clean accumulation clears the flag.
    bus_b.EN = 1'b1; bus_b.InputIn = 8'hFF; bus_b.WeightIn = 8'hFF; bus_b.LastIn = 1'b0;
    step();
    bus_b.LastIn = 1'b1;
    step();
    chk("sat Result",      32'(bus_b.Result),      32'h0000FFFF);
    chk("sat ResultOvf",   32'(bus_b.ResultOvf),   32'd1);
    chk("sat ResultValid", 32'(bus_b.ResultValid), 32'd1);
    bus_b.InputIn = 8'h01; bus_b.WeightIn = 8'h01;
    step();
    chk("unsat Result",    32'(bus_b.Result),      32'd1);
    chk("unsat ResultOvf", 32'(bus_b.ResultOvf),   32'd0);
    bus_b.LastIn = 1'b0;
    step();
    chk("unsat ResultValid", 32'(bus_b.ResultValid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_pe.md
# systolic_pe

Parametrised multiply-accumulate processing element for the accelerator's systolic array. It supersedes the fixed 8-bit PE with five additions:
- configurable data and accumulator widths;
- run-time signed/unsigned arithmetic;
- two dataflow modes: output-stationary (OS) and weight-stationary (WS) with partial-sum chaining;
- saturating accumulation with an overflow flag;
- a LastIn tag that closes an accumulation and emits a one-cycle-valid result.

It tiles horizontally (Input/Last chain) and vertically (Weight/Psum chain) inside the array.

## Interface
Parameters:
- DATA_WIDTH, 8, operand width.
- ACC_WIDTH, 20, accumulator/result/psum width. Must be ≥ 2*DATA_WIDTH.

Ports:
- CLK  in  1  clock, rising edge.
- ASYNC_RST  in  1  asynchronous, active-high reset. Clears every register.
- SYNC_RST  in  1  synchronous clear. Overrides EN. Clears all registers except the stationary weight.
- EN  in  1  advances the PE. When low, every register holds.
- MODE  in  1  0 = OS, 1 = WS.
- SIGNED_MODE  in  1  1 = two's-complement operands and accumulator.
- LoadWeight  in  1  WS only: captures WeightIn into the stationary weight.
- InputIn  in  DATA_WIDTH  activation from the west.
- WeightIn  in  DATA_WIDTH  weight from the north.
- LastIn  in  1  marks the final term of an OS accumulation.
- PsumIn  in  ACC_WIDTH  WS partial sum from the north.
- InputOut  out  DATA_WIDTH  registered InputIn, to the east.
- WeightOut  out  DATA_WIDTH  registered WeightIn, to the south.
- LastOut  out  1  registered LastIn.
- PsumOut  out  ACC_WIDTH  WS registered partial sum. Forced to 0 in OS.
- Result  out  ACC_WIDTH  OS final accumulation. Holds until the next capture.
- ResultValid  out  1  one-cycle pulse after a capture.
- ResultOvf  out  1  saturation occurred during the captured accumulation.

## Operation
- **Reset:** every output is 0 and the stationary weight is 0.
- **Product:** p = InputIn × operand, computed at full 2*DATA_WIDTH.
  - In OS the operand is WeightIn; in WS it is the stationary weight.
  - Sign-extended to ACC_WIDTH when SIGNED_MODE=1, zero-extended otherwise.
- **Saturating add** sat(a+p), computed with one guard bit:
  - signed: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1];
  - unsigned: clamp to [0, 2^ACC_WIDTH-1].
  - A clamp is reported as ovf.
- **Forwarding** (every EN=1 edge, both modes): InputOut←InputIn, WeightOut←WeightIn, LastOut←LastIn.
- **OS mode, EN=1 edge:**
  - LastIn=0: acc←sat(acc+p); ovf_acc←ovf_acc|ovf.
  - LastIn=1: Result←sat(acc+p); ResultOvf←ovf_acc|ovf; ResultValid←1; acc←0; ovf_acc←0.
- **WS mode, EN=1 edge:**
  - LoadWeight=1: stationary weight←WeightIn; PsumOut←PsumIn, passed through unchanged; no MAC.
  - Otherwise: PsumOut←sat(PsumIn+p).
  - In WS, acc, Result and ResultValid are held at their OS values/cleared.
- **ResultValid** is high for exactly one cycle after a capture. It is cleared at the next edge regardless of EN.
- **Mode change:** the PE registers MODE internally. An edge at which MODE differs from the registered value behaves as follows:
  - acc←0 and ovf_acc←0;
  - no MAC or capture that cycle;
  - forwarding still occurs when EN=1.
- **SIGNED_MODE** must be stable for a whole accumulation. A change mid-accumulation is not checked.
- **SYNC_RST=1 edge:** clears acc, ovf_acc, Result, ResultValid, ResultOvf, PsumOut, all forwarding registers and the registered MODE. The stationary weight is preserved.

## Timing
- All forwarded outputs, PsumOut and Result have 1-cycle latency from the EN=1 edge that samples their inputs.
- ResultValid rises at the capture edge and falls at the following edge.
- ASYNC_RST takes effect immediately, mid-cycle, and clears everything. The first active edge is the first rising CLK with ASYNC_RST low.
- Priority at an edge: ASYNC_RST > SYNC_RST > EN > mode-change > LoadWeight/LastIn.
- LastIn together with EN=0: ignored, and the accumulation continues.
- A back-to-back LastIn on consecutive edges yields single-term results. ResultValid stays high across both pulses.

## Test plan
- **OS unsigned** (DATA 8, ACC 20): (5,3) then (7,2) with LastIn on the second → Result=29, ResultValid=1 for one cycle, ResultOvf=0, InputOut=7 and WeightOut=2 one cycle after.
- **OS signed:** (-4,3) then (2,5)+LastIn, SIGNED_MODE=1 → Result=0xFFFFE (-2), ResultOvf=0.
- **Saturation** (ACC 16, unsigned): (255,255)×2, LastIn on the second → Result=0xFFFF, ResultOvf=1. Next (1,1)+LastIn → Result=1, ResultOvf=0.
- **WS:** LoadWeight with WeightIn=6, then InputIn=4, PsumIn=100 → PsumOut=124. Hold EN=0 for 3 cycles → all outputs unchanged. Then SYNC_RST, then InputIn=2, PsumIn=0 → PsumOut=12, showing the weight was preserved.
- **Reset mid-accumulation:** accumulate (5,3), then pulse ASYNC_RST between edges → all outputs 0 before the next edge. Then (1,1)+LastIn → Result=1.
- **Mode switch:** accumulate (5,3) in OS, switch to WS for one edge, return to OS, then (2,2)+LastIn → Result=4. This proves acc is cleared on a mode change.
